// File: rtl/rf_pkg.sv
// Shared register-file types: widths and address/data typedefs used by the
// register file, the write-back arbiter and the hazard unit.
package rf_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 2;
  localparam int NUM_REGS = 2**ADDR_W;

  typedef logic [ADDR_W-1:0] rf_addr_t;
  typedef logic [DATA_W-1:0] rf_data_t;

  // Which requester owns the write port this cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_REQ0 = 2'd1,
    GNT_REQ1 = 2'd2
  } gnt_e;

endpackage

// File: rtl/rf_age_counter.sv
// Saturating wait counter for the low-priority requester. sat_out tells the
// arbiter that req1 has been held off for MAX cycles and must win next.
module rf_age_counter #(
  parameter int MAX = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat_out
);

  localparam int             CW    = (MAX < 1) ? 1 : $clog2(MAX + 1);
  localparam logic [CW-1:0]  MAX_C = CW'(MAX);

  logic [CW-1:0] cnt_q, cnt_d;

  // Clear wins over increment; increment stops at MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != MAX_C))
      cnt_d = cnt_q + 1'b1;
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign sat_out = (cnt_q == MAX_C);

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the register file's single write port. req0 (main
// WB stage) has fixed priority; req1 is aged so it wins after MAX_WAIT cycles
// of being held off. The winning write is registered for one cycle and drives
// the register file, with a one-hot pending mask for hazard detection.
module rf_wb_arbiter #(
  parameter int DATA_W   = rf_pkg::DATA_W,
  parameter int ADDR_W   = rf_pkg::ADDR_W,
  parameter int MAX_WAIT = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req0_valid,
  input  logic [ADDR_W-1:0]        req0_addr,
  input  logic [DATA_W-1:0]        req0_data,
  output logic                     req0_ready,
  input  logic                     req1_valid,
  input  logic [ADDR_W-1:0]        req1_addr,
  input  logic [DATA_W-1:0]        req1_data,
  output logic                     req1_ready,
  output logic                     rf_write,
  output logic [ADDR_W-1:0]        rf_addr,
  output logic [DATA_W-1:0]        rf_data,
  output logic [(2**ADDR_W)-1:0]   pending_mask
);

  localparam int NUM_REGS = 2**ADDR_W;

  rf_pkg::gnt_e      gnt;
  logic              wait_sat;
  logic              age_inc, age_clr;
  logic              hs;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Grant: req0 by default, req1 when alone or once it has aged out.
  // Ready is a pure function of valids and the age state, never of rf_*.
  always_comb begin
    gnt = rf_pkg::GNT_NONE;
    if (!reset) begin
      if (req1_valid && (!req0_valid || wait_sat))
        gnt = rf_pkg::GNT_REQ1;
      else if (req0_valid)
        gnt = rf_pkg::GNT_REQ0;
    end
  end

  assign req0_ready = (gnt == rf_pkg::GNT_REQ0);
  assign req1_ready = (gnt == rf_pkg::GNT_REQ1);

  // req1 ages while it is valid but losing; any req1 handshake or idle
  // cycle restarts the count.
  assign age_inc = req1_valid && !req1_ready;
  assign age_clr = !req1_valid || req1_ready;

  rf_age_counter #(
    .MAX (MAX_WAIT)
  ) u_age (
    .clk     (clk),
    .reset   (reset),
    .inc     (age_inc),
    .clr     (age_clr),
    .sat_out (wait_sat)
  );

  assign hs = (gnt != rf_pkg::GNT_NONE);

  // Output stage next state: capture the granted write, otherwise keep the
  // old address/data (don't-care while rf_write is low).
  always_comb begin
    wr_d   = hs;
    addr_d = addr_q;
    data_d = data_q;
    if (gnt == rf_pkg::GNT_REQ1) begin
      addr_d = req1_addr;
      data_d = req1_data;
    end else if (gnt == rf_pkg::GNT_REQ0) begin
      addr_d = req0_addr;
      data_d = req0_data;
    end
  end

  // Output stage register; drains every cycle so it never back-pressures.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      wr_q   <= wr_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  // A write still sitting in the stage when reset rises must not reach the
  // register file, so the write strobe is masked by reset directly.
  assign rf_write = wr_q && !reset;
  assign rf_addr  = addr_q;
  assign rf_data  = data_q;

  // One-hot of the register being written this cycle, for hazard logic.
  always_comb begin
    pending_mask = '0;
    if (rf_write)
      pending_mask = {{(NUM_REGS-1){1'b0}}, 1'b1} << rf_addr;
  end

endmodule
